// File: rtl/noc_route_splitter_if.sv
// noc_route_splitter_if: one 4-phase req/ack packet channel
interface noc_route_splitter_if #(parameter int W = 57);
  logic req;
  logic ack;
  logic [W-1:0] data;
  modport master(output req, data, input ack);
  modport slave(input req, data, output ack);
endinterface

// File: rtl/noc_route_splitter.sv
// noc_route_splitter: FIFO-buffered 1-to-2 router stage, local vs forward by destination field
module noc_route_splitter #(
  parameter int WIDTH_packet = 57,
  parameter int DEST_LSB = 49,
  parameter int DEST_W = 4,
  parameter logic [DEST_W-1:0] LOCAL_ADDR = '0,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  noc_route_splitter_if.slave in_ch,
  noc_route_splitter_if.master local_ch,
  noc_route_splitter_if.master fwd_ch
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic {IN_IDLE, IN_WAIT} in_state_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_RACK} out_state_t;
  in_state_t in_state, in_next;
  out_state_t out_state, out_next;
  logic [WIDTH_packet-1:0] mem [DEPTH];
  logic [WIDTH_packet-1:0] head, local_q, fwd_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop, sel, head_local, sel_ack;
  assign head = mem[rd_ptr];
  assign head_local = head[DEST_LSB +: DEST_W] == LOCAL_ADDR;
  assign sel_ack = sel ? local_ch.ack : fwd_ch.ack;
  assign in_ch.ack = in_state == IN_WAIT;
  assign local_ch.req = out_state == OUT_REQ && sel;
  assign fwd_ch.req = out_state == OUT_REQ && !sel;
  assign local_ch.data = local_q;
  assign fwd_ch.data = fwd_q;
  // pop looks only at the registered count, so a packet never bypasses the FIFO
  always_comb begin
    push = in_state == IN_IDLE && in_ch.req && count != FULL;
    pop = out_state == OUT_IDLE && count != '0;
    in_next = push ? IN_WAIT : (in_state == IN_WAIT && !in_ch.req) ? IN_IDLE : in_state;
    out_next = pop ? OUT_REQ :
               (out_state == OUT_REQ && sel_ack) ? OUT_RACK :
               (out_state == OUT_RACK && !sel_ack) ? OUT_IDLE : out_state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_state <= IN_IDLE;
      out_state <= OUT_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      sel <= 1'b0;
      local_q <= '0;
      fwd_q <= '0;
    end else begin
      in_state <= in_next;
      out_state <= out_next;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (pop) sel <= head_local;
      if (pop && head_local) local_q <= head;
      if (pop && !head_local) fwd_q <= head;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_ch.data;
  end
endmodule

// File: tb/tb_noc_route_splitter.sv
// tb_noc_route_splitter: directed stimulus with an in-order scoreboard on both output ports
module tb_noc_route_splitter;
  logic clk = 0, reset = 1;
  int checks = 0, failures = 0;
  logic hold_local = 0;
  int max_delay = 0;
  logic [57:0] exp_q[$];
  logic pl = 0, pf = 0;
  noc_route_splitter_if #(57) in_ch();
  noc_route_splitter_if #(57) loc_ch();
  noc_route_splitter_if #(57) fwd_ch();
  noc_route_splitter dut (.clk(clk), .reset(reset), .in_ch(in_ch), .local_ch(loc_ch), .fwd_ch(fwd_ch));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send(input logic [56:0] d);
    int n;
    exp_q.push_back({d[52:49] == 4'd0, d});
    in_ch.data = d;
    in_ch.req = 1;
    for (n = 0; n < 200 && !in_ch.ack; n++) @(negedge clk);
    if (!in_ch.ack) chk("in_ack_timeout", 0, 1);
    in_ch.req = 0;
    for (n = 0; n < 200 && in_ch.ack; n++) @(negedge clk);
    if (in_ch.ack) chk("in_ack_release_timeout", 1, 0);
  endtask
  task automatic drain(input string name);
    for (int n = 0; n < 1000 && (exp_q.size() != 0 || loc_ch.req || fwd_ch.req); n++) @(negedge clk);
    chk(name, 64'(exp_q.size()), 0);
  endtask
  // scoreboard: every new request must match the oldest accepted packet
  always @(negedge clk) begin
    logic [57:0] e;
    if (!reset && ((loc_ch.req && !pl) || (fwd_ch.req && !pf))) begin
      chk("req_exclusive", 64'(loc_ch.req & fwd_ch.req), 0);
      if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("port", 64'(loc_ch.req), 64'(e[57]));
        chk("data", 64'(loc_ch.req ? loc_ch.data : fwd_ch.data), 64'(e[56:0]));
      end
    end
    pl = loc_ch.req;
    pf = fwd_ch.req;
  end
  always begin
    @(negedge clk);
    if (!reset && loc_ch.req && !hold_local) begin
      repeat ($urandom_range(max_delay, 0)) @(negedge clk);
      loc_ch.ack = 1;
      for (int n = 0; n < 200 && loc_ch.req; n++) @(negedge clk);
      loc_ch.ack = 0;
    end
  end
  always begin
    @(negedge clk);
    if (!reset && fwd_ch.req) begin
      repeat ($urandom_range(max_delay, 0)) @(negedge clk);
      fwd_ch.ack = 1;
      for (int n = 0; n < 200 && fwd_ch.req; n++) @(negedge clk);
      fwd_ch.ack = 0;
    end
  end
  initial begin
    in_ch.req = 0;
    in_ch.data = '0;
    loc_ch.ack = 0;
    fwd_ch.ack = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ack", 64'(in_ch.ack), 0);
    chk("rst_local_req", 64'(loc_ch.req), 0);
    chk("rst_fwd_req", 64'(fwd_ch.req), 0);
    reset = 0;
    @(negedge clk);
    // single local packet with exact handshake timing
    exp_q.push_back({1'b1, 57'h0_1234});
    @(posedge clk) #1;
    in_ch.data = 57'h0_1234;
    in_ch.req = 1;
    @(negedge clk);
    chk("lat_in_ack_early", 64'(in_ch.ack), 0);
    @(negedge clk);
    chk("lat_in_ack", 64'(in_ch.ack), 1);
    chk("lat_local_req_early", 64'(loc_ch.req), 0);
    in_ch.req = 0;
    @(negedge clk);
    chk("lat_local_req", 64'(loc_ch.req), 1);
    chk("lat_local_data", 64'(loc_ch.data), 64'h1234);
    chk("lat_fwd_req", 64'(fwd_ch.req), 0);
    drain("drain_single");
    chk("in_ack_low", 64'(in_ch.ack), 0);
    // forward packet: req drops the cycle after ack rises
    send({4'h0, 4'h3, 49'h0_abcd});
    for (int n = 0; n < 20 && !fwd_ch.req; n++) @(negedge clk);
    chk("fwd_req_seen", 64'(fwd_ch.req), 1);
    @(negedge clk);
    chk("fwd_req_drop", 64'(fwd_ch.req), 0);
    chk("fwd_data_hold", 64'(fwd_ch.data), 64'({4'h0, 4'h3, 49'h0_abcd}));
    drain("drain_fwd");
    // backpressure: stalled local port, FIFO fills
    hold_local = 1;
    for (int i = 1; i <= 5; i++) send(57'(i * 16 + 1));
    chk("full_count", 64'(dut.count), 4);
    exp_q.push_back({1'b1, 57'h66});
    in_ch.data = 57'h66;
    in_ch.req = 1;
    repeat (5) @(negedge clk);
    chk("full_backpressure", 64'(in_ch.ack), 0);
    hold_local = 0;
    for (int n = 0; n < 50 && !in_ch.ack; n++) @(negedge clk);
    chk("full_accept_after_pop", 64'(in_ch.ack), 1);
    in_ch.req = 0;
    drain("drain_full");
    // random ack delays on an alternating local/forward stream
    max_delay = 5;
    for (int i = 0; i < 8; i++)
      send({4'h0, (i % 2 == 1) ? 4'(i + 1) : 4'h0, 49'(i * 7919 + 5)});
    drain("drain_stream");
    max_delay = 0;
    // reset mid-handshake with packets buffered
    hold_local = 1;
    for (int i = 0; i < 3; i++) send(57'(i + 200));
    in_ch.data = 57'h1ff;
    in_ch.req = 1;
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("arst_in_ack", 64'(in_ch.ack), 0);
    chk("arst_local_req", 64'(loc_ch.req), 0);
    chk("arst_fwd_req", 64'(fwd_ch.req), 0);
    chk("arst_local_data", 64'(loc_ch.data), 0);
    chk("arst_fwd_data", 64'(fwd_ch.data), 0);
    exp_q.delete();
    in_ch.req = 0;
    hold_local = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("arst_count", 64'(dut.count), 0);
    repeat (10) @(negedge clk);
    chk("arst_silent", 64'(loc_ch.req | fwd_ch.req), 0);
    send({4'h0, 4'h0, 49'h5a5a});
    drain("drain_after_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
